ps2_hack_kbd: RTL
=================

Name: ps2_hack_kbd

Overview:
- Converts MiSTer ps2_key events from hps_io into the 16-bit Hack keyboard word read by the CPU at memory-mapped address 0x6000 (KBD).
- Sits between hps_io and the Nand2Tetris_top memory map, in the clk_sys domain.
- Tracks shift and caps-lock state and which key is currently held.
- KBD shows the Hack code of the most recently pressed, still-held key, and 0 when no key is held.

Parameters:
- CAPS_LOCK_EN, 1: 1 = Caps Lock (scan 0x58) toggles letter case; 0 = scan 0x58 ignored.
- KBD_W, 16: width of the kbd output. Codes are zero-extended to this width.

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  hps_io key event:
  - [10] toggles once per event.
  - [9] 1 = press, 0 = release.
  - [8] extended (E0) prefix.
  - [7:0] PS/2 set-2 scancode.
- kbd  out  KBD_W  Hack key code; 0 = no key.
- kbd_changed  out  1  one-cycle pulse in the cycle kbd takes a new value.
- caps  out  1  current caps-lock state (for an optional LED).

Behaviour:
- Reset (synchronous, active-high): kbd=0, kbd_changed=0, caps=0, shift_l=0, shift_r=0, held=none.
  - prev_toggle is loaded from ps2_key[10] during reset, so no event is detected on the first cycle after reset.
  - Reset asserted mid-pipeline discards any in-flight event.
- Stage 0, cycle N: event detected when the registered ps2_key[10] != prev_toggle. Latch {press, ext, scan}; update prev_toggle.
- Stage 1, cycle N+1: translate using the modifier state at N+1, producing a 9-bit code (0 = unmapped).
- Stage 2, cycle N+2: apply to kbd.
  - Latency is 2 clocks from the cycle in which the toggle change is registered.
  - Events arriving 1 cycle apart are processed strictly in order; no event is dropped.
- Modifiers (no effect on kbd):
  - Scan 0x12 (ext=0) sets/clears shift_l on press/release.
  - Scan 0x59 (ext=0) sets/clears shift_r on press/release.
  - Scan 0x58 press toggles caps; its release is ignored.
  - shift = shift_l | shift_r.
  - A modifier change updates state at stage 0, so it affects the next event translated.
- Translation, non-extended scans:
  - Letters: 0x1C=a, 0x32=b, 0x21=c, 0x23=d, 0x24=e, 0x2B=f, 0x34=g, 0x33=h, 0x43=i, 0x3B=j, 0x42=k, 0x4B=l, 0x3A=m, 0x31=n, 0x44=o, 0x4D=p, 0x15=q, 0x2D=r, 0x1B=s, 0x2C=t, 0x3C=u, 0x2A=v, 0x1D=w, 0x22=x, 0x35=y, 0x1A=z.
  - Letter case: lowercase ASCII; uppercase when shift XOR (caps & CAPS_LOCK_EN).
  - Digits 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45 = '1'..'9','0'. With shift these become !@#$%^&*().
  - Punctuation (US layout, shift variant in parentheses; caps has no effect):
    - 0x4E - (_), 0x55 = (+), 0x54 [ ({), 0x5B ] (}), 0x5D \ (|)
    - 0x4C ; (:), 0x52 ' ("), 0x41 , (<), 0x49 . (>), 0x4A / (?), 0x0E ` (~)
  - Special keys: 0x29 space = 32, 0x5A = 128 (newline), 0x66 = 129 (backspace), 0x76 = 140 (esc).
  - F1..F12 = 141..152 for scans 0x05,0x06,0x04,0x0C,0x03,0x0B,0x83,0x0A,0x01,0x09,0x78,0x07.
- Translation, extended (ext=1):
  - Arrows: 0x6B=130 (left), 0x75=131 (up), 0x74=132 (right), 0x72=133 (down).
  - Navigation: 0x6C=134 (home), 0x69=135 (end), 0x7D=136 (page up), 0x7A=137 (page down), 0x70=138 (insert), 0x71=139 (delete).
  - Extended 0x5A (keypad enter) = 128.
- Any scan not listed is unmapped.
- Apply rules:
  - Press of a mapped key: kbd <= code, held <= {ext, scan}. Pulse kbd_changed if the value differs.
  - Repeated press of the held key (typematic): kbd recomputed with the current modifiers; no pulse if the value is unchanged.
  - Press of an unmapped key: no change.
  - Release matching held: kbd <= 0, held <= none, pulse.
  - Release of any other key: no change. (Rollover: A held, B pressed, B released -> kbd = 0 only when B, the latest held key, is released.)
  - A shift change while a key is held does not re-translate kbd until the next event.
- kbd[KBD_W-1:8] is always 0.

Test Plan:
- Reset, then press 0x1C, release 0x1C -> kbd=0x61 two cycles after the press toggle with a one-cycle kbd_changed; kbd=0 two cycles after the release toggle; caps=0 throughout.
- Press 0x12, press 0x1C, release 0x12, release 0x1C -> kbd=0x41 ('A'); still 0x41 after the shift release; 0 after the 0x1C release.
- Press/release 0x58, then press 0x1C with shift held -> caps=1, kbd=0x61 (shift XOR caps). Repeat with CAPS_LOCK_EN=0 -> kbd=0x41.
- Extended 0x75 press -> kbd=131. Non-extended 0x75 (keypad 8) -> unmapped, kbd stays 0. F7 scan 0x83 -> 147.
- Two toggles 1 cycle apart (press 0x32, then press 0x21) -> kbd=0x62 at N+2, 0x63 at N+3, two kbd_changed pulses.
- reset asserted one cycle after a press toggle -> kbd stays 0, no pulse. Leaving ps2_key[10] constant after reset produces no event.

Source files
------------

// File: rtl/ps2_hack_kbd.sv
// ps2_hack_kbd: turns hps_io ps2_key events into the Hack KBD word.
// Three-stage pipeline: event capture and modifier tracking, translation,
// then apply to the held-key / kbd state.
module ps2_hack_kbd #(
  parameter bit CAPS_LOCK_EN = 1'b1,
  parameter int KBD_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      ps2_key,
  output logic [KBD_W-1:0] kbd,
  output logic             kbd_changed,
  output logic             caps
);

  // Stage 0: event capture and modifier state
  logic       prev_toggle_reg;
  logic       ev0_valid_reg;
  logic       ev0_press_reg;
  logic       ev0_ext_reg;
  logic [7:0] ev0_scan_reg;
  logic       shift_l_reg;
  logic       shift_r_reg;
  logic       caps_reg;

  // Stage 1: translated event
  logic       ev1_valid_reg;
  logic       ev1_press_reg;
  logic [8:0] ev1_key_reg;
  logic [8:0] ev1_code_reg;

  // Stage 2: visible state
  logic [8:0] kbd_reg;
  logic       kbd_changed_reg;
  logic       held_valid_reg;
  logic [8:0] held_key_reg;

  logic       toggle_evt;
  logic       shift;
  logic       upper;
  logic [7:0] letter;
  logic [7:0] fixed_code;
  logic [7:0] plain;
  logic [7:0] shifted;
  logic [8:0] code_next;

  assign toggle_evt = ps2_key[10] ^ prev_toggle_reg;
  assign shift      = shift_l_reg | shift_r_reg;
  assign upper      = shift ^ (caps_reg & CAPS_LOCK_EN);

  // Detect a new event, latch it, and update modifiers immediately so the
  // next event translated already sees them.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_toggle_reg <= ps2_key[10];
      ev0_valid_reg   <= 1'b0;
      shift_l_reg     <= 1'b0;
      shift_r_reg     <= 1'b0;
      caps_reg        <= 1'b0;
    end else begin
      ev0_valid_reg <= toggle_evt;
      if (toggle_evt) begin
        prev_toggle_reg <= ps2_key[10];
        ev0_press_reg   <= ps2_key[9];
        ev0_ext_reg     <= ps2_key[8];
        ev0_scan_reg    <= ps2_key[7:0];
        if (!ps2_key[8] && ps2_key[7:0] == 8'h12) shift_l_reg <= ps2_key[9];
        if (!ps2_key[8] && ps2_key[7:0] == 8'h59) shift_r_reg <= ps2_key[9];
        if (CAPS_LOCK_EN && ps2_key[9] && ps2_key[7:0] == 8'h58) caps_reg <= ~caps_reg;
      end
    end
  end

  // Scancode lookup: letters follow shift^caps, shifted symbols follow shift
  // only, fixed codes ignore modifiers.
  always_comb begin
    letter     = 8'h00;
    fixed_code = 8'h00;
    plain      = 8'h00;
    shifted    = 8'h00;
    if (!ev0_ext_reg) begin
      case (ev0_scan_reg)
        8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
        8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
        8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
        8'h16: begin plain = 8'h31; shifted = 8'h21; end
        8'h1E: begin plain = 8'h32; shifted = 8'h40; end
        8'h26: begin plain = 8'h33; shifted = 8'h23; end
        8'h25: begin plain = 8'h34; shifted = 8'h24; end
        8'h2E: begin plain = 8'h35; shifted = 8'h25; end
        8'h36: begin plain = 8'h36; shifted = 8'h5E; end
        8'h3D: begin plain = 8'h37; shifted = 8'h26; end
        8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
        8'h46: begin plain = 8'h39; shifted = 8'h28; end
        8'h45: begin plain = 8'h30; shifted = 8'h29; end
        8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
        8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
        8'h54: begin plain = 8'h5B; shifted = 8'h7B; end
        8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end
        8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end
        8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end
        8'h52: begin plain = 8'h27; shifted = 8'h22; end
        8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
        8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
        8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end
        8'h0E: begin plain = 8'h60; shifted = 8'h7E; end
        8'h29: fixed_code = 8'd32;
        8'h5A: fixed_code = 8'd128;
        8'h66: fixed_code = 8'd129;
        8'h76: fixed_code = 8'd140;
        8'h05: fixed_code = 8'd141;  8'h06: fixed_code = 8'd142;
        8'h04: fixed_code = 8'd143;  8'h0C: fixed_code = 8'd144;
        8'h03: fixed_code = 8'd145;  8'h0B: fixed_code = 8'd146;
        8'h83: fixed_code = 8'd147;  8'h0A: fixed_code = 8'd148;
        8'h01: fixed_code = 8'd149;  8'h09: fixed_code = 8'd150;
        8'h78: fixed_code = 8'd151;  8'h07: fixed_code = 8'd152;
        default: ;
      endcase
    end else begin
      case (ev0_scan_reg)
        8'h6B: fixed_code = 8'd130;  8'h75: fixed_code = 8'd131;
        8'h74: fixed_code = 8'd132;  8'h72: fixed_code = 8'd133;
        8'h6C: fixed_code = 8'd134;  8'h69: fixed_code = 8'd135;
        8'h7D: fixed_code = 8'd136;  8'h7A: fixed_code = 8'd137;
        8'h70: fixed_code = 8'd138;  8'h71: fixed_code = 8'd139;
        8'h5A: fixed_code = 8'd128;
        default: ;
      endcase
    end
    if (letter != 8'h00)          code_next = {1'b0, upper ? (letter - 8'd32) : letter};
    else if (fixed_code != 8'h00) code_next = {1'b0, fixed_code};
    else                          code_next = {1'b0, shift ? shifted : plain};
  end

  // Stage 1 register: carry the translated code forward with its key identity.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev1_valid_reg <= 1'b0;
    end else begin
      ev1_valid_reg <= ev0_valid_reg;
      ev1_press_reg <= ev0_press_reg;
      ev1_key_reg   <= {ev0_ext_reg, ev0_scan_reg};
      ev1_code_reg  <= code_next;
    end
  end

  // Apply: a mapped press takes over kbd, only the latest held key's
  // release clears it; the pulse fires only on a real value change.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_reg         <= 9'd0;
      kbd_changed_reg <= 1'b0;
      held_valid_reg  <= 1'b0;
      held_key_reg    <= 9'd0;
    end else begin
      kbd_changed_reg <= 1'b0;
      if (ev1_valid_reg) begin
        if (ev1_press_reg) begin
          if (ev1_code_reg != 9'd0) begin
            kbd_reg         <= ev1_code_reg;
            held_valid_reg  <= 1'b1;
            held_key_reg    <= ev1_key_reg;
            kbd_changed_reg <= (ev1_code_reg != kbd_reg);
          end
        end else if (held_valid_reg && held_key_reg == ev1_key_reg) begin
          kbd_reg         <= 9'd0;
          held_valid_reg  <= 1'b0;
          kbd_changed_reg <= (kbd_reg != 9'd0);
        end
      end
    end
  end

  // Zero-extend the 9-bit code to the configured output width.
  genvar gi;
  generate
    for (gi = 0; gi < KBD_W; gi++) begin : g_kbd
      if (gi < 9) begin : g_code
        assign kbd[gi] = kbd_reg[gi];
      end else begin : g_zero
        assign kbd[gi] = 1'b0;
      end
    end
  endgenerate

  assign kbd_changed = kbd_changed_reg;
  assign caps        = caps_reg;

endmodule
